// File: rtl/rail_pwrgd_monitor.sv
// Per-rail enable/power-good responder for the master sequencer.
// Filters regulator power-good and latches ramp/drop/discharge faults.
module rail_pwrgd_monitor #(
  parameter int unsigned TICK_DIV    = 2000,
  parameter int unsigned DEB_CYC     = 8,
  parameter int unsigned RAMP_TMO_MS = 20,
  parameter int unsigned OFF_TMO_MS  = 150
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRail_EN,
  input  logic       iPWRGD_Raw,
  input  logic       iFault_Clear,
  output logic       oRail_EN,
  output logic       oPWRGD,
  output logic       oFault,
  output logic [1:0] oFault_Code,
  output logic [2:0] oDBG_FSM
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [15:0]   RAMP_LAST = 16'(RAMP_TMO_MS - 1);
  localparam logic [15:0]   OFF_LAST  = 16'(OFF_TMO_MS - 1);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_RAMP = 3'd1,
    S_ON   = 3'd2,
    S_DIS  = 3'd3,
    S_FLT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      code_q, code_d;
  logic            sync1_q, sync2_q;
  logic            pgf_q;
  logic [DW-1:0]   deb_q;
  logic [PW-1:0]   pre_q;
  logic [15:0]     ms_q;
  logic            rail_q, pg_q, flt_q;
  logic            pre_wrap;
  logic            ramp_tmo;
  logic            off_tmo;

  // Timeout fires on the edge that completes N ms since state entry.
  assign pre_wrap = (pre_q == PRE_LAST);
  assign ramp_tmo = pre_wrap && (ms_q >= RAMP_LAST);
  assign off_tmo  = pre_wrap && (ms_q >= OFF_LAST);

  // Synchronize raw power-good and accept a level only once it holds.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pgf_q   <= 1'b0;
      deb_q   <= '0;
    end else begin
      sync1_q <= iPWRGD_Raw;
      sync2_q <= sync1_q;
      if (sync2_q == pgf_q) begin
        deb_q <= '0;
      end else if (deb_q == DEB_LAST) begin
        pgf_q <= sync2_q;
        deb_q <= '0;
      end else begin
        deb_q <= deb_q + 1'b1;
      end
    end
  end

  // Next-state and fault-cause selection in priority order per state.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_OFF: begin
        if (iRail_EN) state_d = S_RAMP;
      end
      S_RAMP: begin
        if (!iRail_EN) begin
          state_d = S_DIS;
        end else if (pgf_q) begin
          state_d = S_ON;
        end else if (ramp_tmo) begin
          state_d = S_FLT;
          code_d  = 2'd1;
        end
      end
      S_ON: begin
        if (!iRail_EN) begin
          state_d = S_DIS;
        end else if (!pgf_q) begin
          state_d = S_FLT;
          code_d  = 2'd2;
        end
      end
      S_DIS: begin
        if (!pgf_q) begin
          state_d = S_OFF;
        end else if (off_tmo) begin
          state_d = S_FLT;
          code_d  = 2'd3;
        end
      end
      S_FLT: begin
        if (iFault_Clear && !iRail_EN) begin
          state_d = S_OFF;
          code_d  = 2'd0;
        end
      end
      default: begin
        state_d = S_FLT;
        code_d  = 2'd0;
      end
    endcase
  end

  // State, state timer and registered outputs for the entered state.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_OFF;
      code_q  <= 2'd0;
      pre_q   <= '0;
      ms_q    <= 16'd0;
      rail_q  <= 1'b0;
      pg_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      rail_q  <= (state_d == S_RAMP) || (state_d == S_ON);
      pg_q    <= (state_d == S_ON);
      flt_q   <= (state_d == S_FLT);
      if (state_d != state_q) begin
        pre_q <= '0;
        ms_q  <= 16'd0;
      end else if (pre_wrap) begin
        pre_q <= '0;
        if (ms_q != 16'hFFFF) ms_q <= ms_q + 16'd1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign oRail_EN    = rail_q;
  assign oPWRGD      = pg_q;
  assign oFault      = flt_q;
  assign oFault_Code = code_q;
  assign oDBG_FSM    = state_q;

endmodule

// File: tb/tb_rail_pwrgd_monitor.sv
// Directed bench for rail_pwrgd_monitor with a cycle-level reference
// model built from sample history and elapsed-time arithmetic.
module tb_rail_pwrgd_monitor;

  localparam int TICK = 4;
  localparam int DEB  = 3;
  localparam int RTMO = 5;
  localparam int OTMO = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       raw;
  logic       clr;
  logic       o_en;
  logic       o_pg;
  logic       o_flt;
  logic [1:0] o_code;
  logic [2:0] o_dbg;

  int nvec = 0;
  int nerr = 0;

  rail_pwrgd_monitor #(
    .TICK_DIV(TICK),
    .DEB_CYC(DEB),
    .RAMP_TMO_MS(RTMO),
    .OFF_TMO_MS(OTMO)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .iRail_EN(en),
    .iPWRGD_Raw(raw),
    .iFault_Clear(clr),
    .oRail_EN(o_en),
    .oPWRGD(o_pg),
    .oFault(o_flt),
    .oFault_Code(o_code),
    .oDBG_FSM(o_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  bit m_valid = 0;
  int cyc = 0;
  int entry = 0;
  int m_state = 0;
  int m_code = 0;
  bit m_pgf = 0;
  bit hist[$];

  task automatic model_step();
    int ns;
    int nc;
    int el;
    bit diff;
    cyc++;
    if (rst) begin
      m_valid = 1;
      m_state = 0;
      m_code = 0;
      m_pgf = 0;
      entry = cyc;
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
      return;
    end
    ns = m_state;
    nc = m_code;
    el = cyc - entry;
    case (m_state)
      0: if (en) ns = 1;
      1: begin
        if (!en) ns = 3;
        else if (m_pgf) ns = 2;
        else if (el >= RTMO * TICK) begin ns = 4; nc = 1; end
      end
      2: begin
        if (!en) ns = 3;
        else if (!m_pgf) begin ns = 4; nc = 2; end
      end
      3: begin
        if (!m_pgf) ns = 0;
        else if (el >= OTMO * TICK) begin ns = 4; nc = 3; end
      end
      default: begin
        if (clr && !en) begin ns = 0; nc = 0; end
      end
    endcase
    // filtered level flips when the last DEB synchronized samples differ
    diff = 1;
    for (int k = 1; k <= DEB; k++)
      if (hist[k] == m_pgf) diff = 0;
    if (diff) m_pgf = ~m_pgf;
    hist.push_front(raw);
    hist.pop_back();
    if (ns != m_state) entry = cyc;
    m_state = ns;
    m_code = nc;
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      if (m_valid) begin
        chk("m_rail", o_en, (m_state == 1 || m_state == 2));
        chk("m_pg", o_pg, (m_state == 2));
        chk("m_flt", o_flt, (m_state == 4));
        chk("m_code", o_code, m_code);
        chk("m_dbg", o_dbg, m_state);
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 0; raw = 0; clr = 0;
    nclk(2);
    chk("rst_rail", o_en, 0);
    chk("rst_pg", o_pg, 0);
    chk("rst_flt", o_flt, 0);
    chk("rst_code", o_code, 0);
    chk("rst_dbg", o_dbg, 0);
    rst = 0;
    nclk(1);

    // 1. normal cycle
    en = 1;
    nclk(1);
    chk("t1_rail_on", o_en, 1);
    chk("t1_ramp", o_dbg, 1);
    nclk(7);
    raw = 1;
    nclk(5);
    chk("t1_pg_early", o_pg, 0);
    nclk(1);
    chk("t1_pg_on", o_pg, 1);
    chk("t1_on", o_dbg, 2);
    en = 0;
    nclk(1);
    chk("t1_rail_off", o_en, 0);
    chk("t1_pg_off", o_pg, 0);
    chk("t1_dis", o_dbg, 3);
    nclk(3);
    raw = 0;
    nclk(5);
    chk("t1_dis_hold", o_dbg, 3);
    nclk(1);
    chk("t1_off", o_dbg, 0);
    nclk(2);

    // 2. ramp timeout
    en = 1;
    nclk(20);
    chk("t2_ramp19", o_dbg, 1);
    nclk(1);
    chk("t2_flt_state", o_dbg, 4);
    chk("t2_flt", o_flt, 1);
    chk("t2_code", o_code, 1);
    chk("t2_rail", o_en, 0);

    // 5. fault clear rules
    nclk(1);
    clr = 1;
    nclk(1);
    clr = 0;
    nclk(1);
    chk("t5_hold", o_dbg, 4);
    chk("t5_hold_flt", o_flt, 1);
    en = 0;
    clr = 1;
    nclk(1);
    clr = 0;
    chk("t5_off", o_dbg, 0);
    chk("t5_flt_clr", o_flt, 0);
    chk("t5_code_clr", o_code, 0);
    nclk(2);

    // 3. glitch filter
    en = 1;
    raw = 1;
    nclk(12);
    chk("t3_on", o_dbg, 2);
    raw = 0;
    nclk(2);
    raw = 1;
    nclk(8);
    chk("t3_g2_pg", o_pg, 1);
    chk("t3_g2_flt", o_flt, 0);
    raw = 0;
    nclk(4);
    raw = 1;
    nclk(1);
    chk("t3_g4_pg_hold", o_pg, 1);
    nclk(1);
    chk("t3_g4_flt", o_flt, 1);
    chk("t3_g4_code", o_code, 2);
    chk("t3_g4_pg", o_pg, 0);
    chk("t3_g4_rail", o_en, 0);
    en = 0;
    clr = 1;
    nclk(1);
    clr = 0;
    chk("t3_clr", o_dbg, 0);
    nclk(8);

    // 4. discharge timeout
    en = 1;
    nclk(12);
    chk("t4_on", o_dbg, 2);
    en = 0;
    nclk(1);
    chk("t4_dis", o_dbg, 3);
    nclk(4);
    en = 1;
    nclk(5);
    chk("t4_rail_stay", o_en, 0);
    chk("t4_dis_stay", o_dbg, 3);
    nclk(10);
    chk("t4_dis19", o_dbg, 3);
    nclk(1);
    chk("t4_flt", o_dbg, 4);
    chk("t4_code", o_code, 3);
    en = 0;
    clr = 1;
    nclk(1);
    clr = 0;
    chk("t4_clr", o_dbg, 0);
    nclk(2);

    // 6. reset mid-ON
    en = 1;
    nclk(12);
    chk("t6_on", o_dbg, 2);
    rst = 1;
    nclk(1);
    rst = 0;
    chk("t6_rail", o_en, 0);
    chk("t6_pg", o_pg, 0);
    chk("t6_flt", o_flt, 0);
    chk("t6_code", o_code, 0);
    chk("t6_dbg", o_dbg, 0);
    nclk(1);
    chk("t6_ramp", o_dbg, 1);
    chk("t6_rail_on", o_en, 1);
    nclk(10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
